// File: rtl/press_timer.sv
// press_timer: per-channel button synchroniser, debouncer and press-duration
// timer. Each finished press duration is held until the game logic acks it.
module press_timer #(
  parameter int N_CH     = 2,
  parameter int TIME_W   = 4,
  parameter int TICK_DIV = 4,
  parameter int DEB_CYC  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          btn,
  output logic [N_CH-1:0]          is_pressing,
  output logic [N_CH*TIME_W-1:0]   press_time,
  output logic [N_CH-1:0]          press_sat,
  output logic [N_CH-1:0]          release_valid,
  output logic [N_CH*TIME_W-1:0]   release_time,
  input  logic [N_CH-1:0]          release_ack
);

  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int SUB_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYC - 1);
  localparam logic [SUB_W-1:0]  SUB_MAX  = SUB_W'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0] TIME_MAX = {TIME_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESSING = 2'd1,
    DONE     = 2'd2
  } state_e;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic              sync1_q, sync2_q;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              deb_q, deb_d, deb_prev_q;
    logic              rise, fall;
    state_e            state_q, state_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [TIME_W-1:0] rel_q, rel_d;
    logic              sat_q, sat_d;

    // Debounce: count disagreeing samples, toggle the level after DEB_CYC of them.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
      deb_cnt_d = '0;
      deb_d     = deb_q;
      if (sync2_q != deb_q) begin
        if (deb_cnt_q == DEB_MAX) begin
          deb_d = ~deb_q;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
    end

    // Synchroniser, debounce counter/level and edge-detect history.
    // NOTE: sequential state uses non-blocking assignments so every flop updates together.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_cnt_q  <= '0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
      end else begin
        sync1_q    <= btn[ch];
        sync2_q    <= sync1_q;
        deb_cnt_q  <= deb_cnt_d;
        deb_q      <= deb_d;
        deb_prev_q <= deb_q;
      end
    end

    assign rise = deb_q & ~deb_prev_q;
    assign fall = ~deb_q & deb_prev_q;

    // Press FSM next state: start on rise, tick while held, capture on fall.
    always_comb begin
      state_d = state_q;
      sub_d   = sub_q;
      time_d  = time_q;
      sat_d   = sat_q;
      rel_d   = rel_q;
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = PRESSING;
            sub_d   = '0;
            time_d  = '0;
            sat_d   = 1'b0;
          end
        end
        PRESSING: begin
          if (sub_q == SUB_MAX) begin
            sub_d = '0;
            if (time_q != TIME_MAX) time_d = time_q + 1'b1;
          end else begin
            sub_d = sub_q + 1'b1;
          end
          if (time_d == TIME_MAX) sat_d = 1'b1;
          // The capture includes a tick landing on the same edge as the fall.
          if (fall) begin
            state_d = DONE;
            rel_d   = time_d;
          end
        end
        DONE: begin
          // Rises seen here are dropped; the result waits for its ack.
          if (release_ack[ch]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Press FSM registers.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        sub_q   <= '0;
        time_q  <= '0;
        sat_q   <= 1'b0;
        rel_q   <= '0;
      end else begin
        state_q <= state_d;
        sub_q   <= sub_d;
        time_q  <= time_d;
        sat_q   <= sat_d;
        rel_q   <= rel_d;
      end
    end

    assign is_pressing[ch]                    = (state_q == PRESSING);
    assign release_valid[ch]                  = (state_q == DONE);
    assign press_sat[ch]                      = sat_q;
    assign press_time[ch*TIME_W +: TIME_W]    = time_q;
    assign release_time[ch*TIME_W +: TIME_W]  = rel_q;
  end

endmodule
